// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and types for the hazard controller slice.
package hazard_pkg;

    // Forwarding mux select encodings.
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // MDU scoreboard state.
    typedef enum logic {
        SB_IDLE = 1'b0,
        SB_BUSY = 1'b1
    } sb_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit signal bundle. Inputs here are level signals sampled
// every cycle; there is no valid/ready handshake, the only event input is the
// one-cycle MduDone pulse. SbState is a debug view of the scoreboard FSM.
interface hazard_ctrl_if #(
    parameter int AW    = 5,
    parameter int CNT_W = 32
);
    import hazard_pkg::*;

    logic [AW-1:0]    Rs1D, Rs2D, RdD;
    logic             Rs1UsedD, Rs2UsedD, RegWriteD, MduStartD;
    logic [AW-1:0]    Rs1E, Rs2E, RdE;
    logic             ResultSrcEb0, MduStartE, PCSrcE;
    logic [AW-1:0]    RdM, RdW;
    logic             RegWriteM, RegWriteW;
    logic             MemReqM, DmemReadyM;
    logic             MduDone;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE, StallM;
    logic             FlushD, FlushE;
    logic             MduBusy, MduTimeout;
    logic [CNT_W-1:0] StallCnt;
    sb_state_t        SbState;

    modport master (
        output Rs1D, Rs2D, RdD, Rs1UsedD, Rs2UsedD, RegWriteD, MduStartD,
               Rs1E, Rs2E, RdE, ResultSrcEb0, MduStartE, PCSrcE,
               RdM, RdW, RegWriteM, RegWriteW, MemReqM, DmemReadyM, MduDone,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
               FlushD, FlushE, MduBusy, MduTimeout, StallCnt, SbState
    );

    modport slave (
        input  Rs1D, Rs2D, RdD, Rs1UsedD, Rs2UsedD, RegWriteD, MduStartD,
               Rs1E, Rs2E, RdE, ResultSrcEb0, MduStartE, PCSrcE,
               RdM, RdW, RegWriteM, RegWriteW, MemReqM, DmemReadyM, MduDone,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
               FlushD, FlushE, MduBusy, MduTimeout, StallCnt, SbState
    );

endinterface

// File: rtl/hazard_ctrl_mdu_scoreboard.sv
// Tracks one outstanding multiply/divide op: its destination register and
// how long it has been in flight, raising a sticky timeout flag if it never ends.
module mdu_scoreboard
    import hazard_pkg::*;
#(
    parameter int AW      = 5,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stall,
    input  logic          done,
    input  logic [AW-1:0] rd,
    output logic          busy,
    output logic [AW-1:0] pend_rd,
    output logic          timeout,
    output sb_state_t     state
);

    localparam int          CW     = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

    sb_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [AW-1:0] pend_q;
    logic          timeout_q;
    logic          capture;
    logic          inc;

    // A start held in E by a memory freeze has not really issued yet.
    assign capture = start & ~stall;
    assign inc     = (state_q == SB_BUSY) & ~capture & ~done & (cnt_q != TO_VAL);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= SB_IDLE;
        else        state_q <= state_d;
    end

    // Next state: a new issue wins over completion so back-to-back ops stay BUSY.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SB_IDLE: if (capture) state_d = SB_BUSY;
            SB_BUSY: if (capture) state_d = SB_BUSY;
                     else if (done) state_d = SB_IDLE;
            default: state_d = SB_IDLE;
        endcase
    end

    // Pending destination, in-flight cycle counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q    <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (capture) begin
                pend_q <= rd;
                cnt_q  <= '0;
            end else if (inc) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (inc && (cnt_q == TO_VAL - 1'b1)) timeout_q <= 1'b1;
        end
    end

    // Outputs decoded from the registered state.
    always_comb begin
        busy    = (state_q == SB_BUSY);
        state   = state_q;
        pend_rd = pend_q;
        timeout = timeout_q;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 pipeline: operand forwarding,
// load-use and MDU interlocks, memory-wait freeze and a stall-cycle counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int AW      = 5,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input logic         clk,
    input logic         rst_n,
    hazard_ctrl_if.slave hz
);

    logic          mem_stall, lw_stall, mdu_stall;
    logic          raw_hit, waw_hit;
    logic          sb_busy, sb_timeout;
    logic [AW-1:0] pend_rd;
    sb_state_t     sb_state;
    logic [CNT_W-1:0] stall_cnt_q;

    // x0 is never forwarded; M is younger than W so it wins.
    function automatic logic [1:0] fwd_sel(input logic [AW-1:0] rs,
                                           input logic [AW-1:0] rd_m, input logic we_m,
                                           input logic [AW-1:0] rd_w, input logic we_w);
        if (rs == '0)                 return FWD_RF;
        else if (we_m && rs == rd_m)  return FWD_M;
        else if (we_w && rs == rd_w)  return FWD_W;
        else                          return FWD_RF;
    endfunction

    mdu_scoreboard #(.AW(AW), .TIMEOUT(TIMEOUT)) u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (hz.MduStartE),
        .stall   (mem_stall),
        .done    (hz.MduDone),
        .rd      (hz.RdE),
        .busy    (sb_busy),
        .pend_rd (pend_rd),
        .timeout (sb_timeout),
        .state   (sb_state)
    );

    // Hazard detection terms.
    always_comb begin
        mem_stall = hz.MemReqM & ~hz.DmemReadyM;
        lw_stall  = hz.ResultSrcEb0 & (hz.RdE != '0) &
                    ((hz.Rs1UsedD & (hz.Rs1D == hz.RdE)) |
                     (hz.Rs2UsedD & (hz.Rs2D == hz.RdE)));
        raw_hit   = (pend_rd != '0) &
                    ((hz.Rs1UsedD & (hz.Rs1D == pend_rd)) |
                     (hz.Rs2UsedD & (hz.Rs2D == pend_rd)));
        waw_hit   = hz.RegWriteD & (hz.RdD == pend_rd) & (hz.RdD != '0);
        mdu_stall = sb_busy & (raw_hit | waw_hit | hz.MduStartD);
    end

    // Forwarding selects and stall/flush priority: freeze, redirect, interlock.
    always_comb begin
        hz.ForwardAE = fwd_sel(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
        hz.ForwardBE = fwd_sel(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
        hz.StallF = 1'b0;
        hz.StallD = 1'b0;
        hz.StallE = 1'b0;
        hz.StallM = 1'b0;
        hz.FlushD = 1'b0;
        hz.FlushE = 1'b0;
        if (mem_stall) begin
            hz.StallF = 1'b1;
            hz.StallD = 1'b1;
            hz.StallE = 1'b1;
            hz.StallM = 1'b1;
        end else if (hz.PCSrcE) begin
            hz.FlushD = 1'b1;
            hz.FlushE = 1'b1;
        end else if (lw_stall || mdu_stall) begin
            hz.StallF = 1'b1;
            hz.StallD = 1'b1;
            hz.FlushE = 1'b1;
        end
    end

    // Saturating count of cycles in which decode was held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                 stall_cnt_q <= '0;
        else if (hz.StallD && (stall_cnt_q != '1))  stall_cnt_q <= stall_cnt_q + 1'b1;
    end

    assign hz.StallCnt   = stall_cnt_q;
    assign hz.MduBusy    = sb_busy;
    assign hz.MduTimeout = sb_timeout;
    assign hz.SbState    = sb_state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with TIMEOUT=8.
module tb_hazard_ctrl;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    hazard_ctrl_if #(.AW(5), .CNT_W(32)) hz ();

    hazard_ctrl #(.AW(5), .TIMEOUT(8), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // {StallF, StallD, StallE, StallM, FlushD, FlushE}
    function automatic logic [31:0] ctl();
        return {26'd0, hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        hz.Rs1D = '0; hz.Rs2D = '0; hz.RdD = '0;
        hz.Rs1UsedD = 0; hz.Rs2UsedD = 0; hz.RegWriteD = 0; hz.MduStartD = 0;
        hz.Rs1E = '0; hz.Rs2E = '0; hz.RdE = '0;
        hz.ResultSrcEb0 = 0; hz.MduStartE = 0; hz.PCSrcE = 0;
        hz.RdM = '0; hz.RdW = '0; hz.RegWriteM = 0; hz.RegWriteW = 0;
        hz.MemReqM = 0; hz.DmemReadyM = 1; hz.MduDone = 0;
    endtask

    initial begin
        // Reset state.
        rst_n = 1'b0;
        clr();
        #3;
        chk("rst_busy", {31'd0, hz.MduBusy}, 32'd0);
        chk("rst_timeout", {31'd0, hz.MduTimeout}, 32'd0);
        chk("rst_cnt", hz.StallCnt, 32'd0);
        chk("rst_ctl", ctl(), 32'h00);
        hz.Rs1E = 5'd5; hz.RdM = 5'd5; hz.RegWriteM = 1;
        #1;
        chk("rst_fwd_live", {30'd0, hz.ForwardAE}, 32'd2);
        clr();
        tick();
        rst_n = 1'b1;

        // Forwarding priority and x0.
        tick();
        hz.Rs1E = 5'd5; hz.Rs2E = 5'd5; hz.RdM = 5'd5; hz.RegWriteM = 1;
        hz.RdW = 5'd5; hz.RegWriteW = 1;
        #1;
        chk("fwd_a_m", {30'd0, hz.ForwardAE}, 32'd2);
        chk("fwd_b_m", {30'd0, hz.ForwardBE}, 32'd2);
        tick();
        hz.Rs1E = 5'd0;
        #1;
        chk("fwd_a_x0", {30'd0, hz.ForwardAE}, 32'd0);
        tick();
        hz.Rs1E = 5'd5; hz.RegWriteM = 0; hz.Rs2E = 5'd6;
        #1;
        chk("fwd_a_w", {30'd0, hz.ForwardAE}, 32'd1);
        chk("fwd_b_rf", {30'd0, hz.ForwardBE}, 32'd0);
        chk("fwd_cnt", hz.StallCnt, 32'd0);

        // Load-use: x0 and unused sources never stall.
        tick();
        clr();
        hz.ResultSrcEb0 = 1; hz.RdE = 5'd0; hz.Rs1UsedD = 1; hz.Rs1D = 5'd0;
        #1;
        chk("lw_x0", ctl(), 32'h00);
        tick();
        hz.RdE = 5'd7; hz.Rs2D = 5'd7; hz.Rs2UsedD = 0;
        #1;
        chk("lw_unused", ctl(), 32'h00);
        tick();
        hz.Rs2UsedD = 1;
        #1;
        chk("lw_stall", ctl(), 32'h31);
        tick();
        clr();
        #1;
        chk("lw_release", ctl(), 32'h00);
        chk("lw_cnt", hz.StallCnt, 32'd1);

        // MDU RAW interlock until MduDone.
        hz.MduStartE = 1; hz.RdE = 5'd9;
        #1;
        chk("mdu_idle", {31'd0, hz.MduBusy}, 32'd0);
        tick();
        clr();
        hz.Rs1UsedD = 1; hz.Rs1D = 5'd9;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mdu_raw_hold", ctl(), 32'h31);
            chk("mdu_busy", {31'd0, hz.MduBusy}, 32'd1);
            tick();
        end
        hz.MduDone = 1;
        #1;
        chk("mdu_done_stall", ctl(), 32'h31);
        chk("mdu_done_busy", {31'd0, hz.MduBusy}, 32'd1);
        tick();
        hz.MduDone = 0;
        #1;
        chk("mdu_after_busy", {31'd0, hz.MduBusy}, 32'd0);
        chk("mdu_after_ctl", ctl(), 32'h00);
        chk("mdu_cnt", hz.StallCnt, 32'd5);

        // Memory freeze outranks redirect and load-use.
        clr();
        hz.MemReqM = 1; hz.DmemReadyM = 0; hz.PCSrcE = 1;
        hz.ResultSrcEb0 = 1; hz.RdE = 5'd7; hz.Rs1UsedD = 1; hz.Rs1D = 5'd7;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mem_freeze", ctl(), 32'h3C);
            tick();
        end
        hz.DmemReadyM = 1;
        #1;
        chk("mem_release_flush", ctl(), 32'h03);
        tick();
        chk("mem_cnt", hz.StallCnt, 32'd8);

        // Timeout after 8 busy cycles, then async reset mid-operation.
        clr();
        hz.MduStartE = 1; hz.RdE = 5'd12;
        tick();
        clr();
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("to_not_yet", {31'd0, hz.MduTimeout}, 32'd0);
        end
        tick();
        chk("to_set", {31'd0, hz.MduTimeout}, 32'd1);
        tick();
        tick();
        chk("to_sticky", {31'd0, hz.MduTimeout}, 32'd1);
        chk("to_still_busy", {31'd0, hz.MduBusy}, 32'd1);
        chk("to_cnt_before", hz.StallCnt, 32'd8);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, hz.MduBusy}, 32'd0);
        chk("arst_timeout", {31'd0, hz.MduTimeout}, 32'd0);
        chk("arst_cnt", hz.StallCnt, 32'd0);
        #1;
        rst_n = 1'b1;

        // Back-to-back: done and new start together reload PendRd.
        tick();
        hz.MduStartE = 1; hz.RdE = 5'd9;
        tick();
        clr();
        tick();
        hz.MduDone = 1; hz.MduStartE = 1; hz.RdE = 5'd3;
        tick();
        clr();
        hz.Rs1UsedD = 1; hz.Rs1D = 5'd9;
        #1;
        chk("b2b_busy", {31'd0, hz.MduBusy}, 32'd1);
        chk("b2b_old_pend", ctl(), 32'h00);
        tick();
        hz.Rs1D = 5'd3;
        #1;
        chk("b2b_new_raw", ctl(), 32'h31);
        tick();
        clr();
        hz.RegWriteD = 1; hz.RdD = 5'd3;
        #1;
        chk("mdu_waw", ctl(), 32'h31);
        tick();
        clr();
        hz.MduStartD = 1;
        #1;
        chk("mdu_struct", ctl(), 32'h31);
        hz.PCSrcE = 1;
        #1;
        chk("redirect_drops_stall", ctl(), 32'h03);
        tick();
        clr();
        hz.MduDone = 1;
        tick();
        clr();
        #1;
        chk("b2b_idle", {31'd0, hz.MduBusy}, 32'd0);

        // Pending x0 never interlocks.
        hz.MduStartE = 1; hz.RdE = 5'd0;
        tick();
        clr();
        hz.Rs1UsedD = 1; hz.Rs1D = 5'd0;
        #1;
        chk("pend_x0_busy", {31'd0, hz.MduBusy}, 32'd1);
        chk("pend_x0_nostall", ctl(), 32'h00);
        hz.MduDone = 1;
        tick();
        clr();

        // A start frozen by memory wait is not captured.
        hz.MduStartE = 1; hz.RdE = 5'd4; hz.MemReqM = 1; hz.DmemReadyM = 0;
        #1;
        chk("frz_ctl", ctl(), 32'h3C);
        tick();
        clr();
        #1;
        chk("frz_no_capture", {31'd0, hz.MduBusy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
